fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencer for the combinational instruction-fetch unit `fetch`: owns the program counter, drives `fetch`'s pc input and captures its `inst`/`pc_4` outputs.
- Presents fetched instructions to decode through a one-entry valid/ready pipeline register.
- Supports start, downstream stall, branch redirect with squash, and halt at end of program.
- Word-addressed PC: next sequential PC is pc+1, as returned by `fetch`.

Parameters:
- PC_W, 32, PC and address width
- INST_W, 32, instruction width
- RESET_PC, 0, PC loaded on start and on reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run from RESET_PC (honoured in IDLE or HALT)
- prog_len  in  PC_W  number of instructions in the program; sampled on start
- redirect_valid  in  1  branch/jump redirect request
- redirect_pc  in  PC_W  redirect target
- fe_pc  out  PC_W  to `fetch` pc input (equals internal pc register)
- fe_inst  in  INST_W  from `fetch` inst (combinational on fe_pc)
- fe_pc_4  in  PC_W  from `fetch` pc_4
- out_valid  out  1  out_inst/out_pc hold a valid instruction
- out_ready  in  1  decode accepts this cycle
- out_inst  out  INST_W  registered instruction
- out_pc  out  PC_W  PC of out_inst
- busy  out  1  state == RUN
- halted  out  1  state == HALT

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, pc=RESET_PC, len_q=0, out_valid=0, out_inst=0, out_pc=0, busy=0, halted=0. Reset overrides all other inputs, including mid-run.
- States: IDLE, RUN, HALT; 2-bit encoding.
- Transitions:
  - IDLE --start--> RUN: pc=RESET_PC, len_q=prog_len. If prog_len==0, go to HALT instead.
  - RUN --last fetch, or redirect out of range--> HALT.
  - HALT --start--> RUN, same actions as from IDLE.
  - start in RUN is ignored.
- fetch_en = (state==RUN) && (!out_valid || out_ready) && !redirect_valid.
- On fetch_en: out_inst<=fe_inst, out_pc<=pc, out_valid<=1, pc<=fe_pc_4. If pc==len_q-1, state<=HALT.
- Handshake rules:
  - Transfer occurs when out_valid && out_ready.
  - Transfer without a new fetch clears out_valid.
  - While !out_ready, out_valid/out_inst/out_pc hold stable and pc does not advance.
- Throughput: one instruction per cycle while out_ready stays high.
- Latency: start sampled at edge N; first out_valid=1 after edge N+1.
- Redirect (RUN only; ignored in IDLE/HALT):
  - At the edge: out_valid<=0 (squash, even if out_ready is high that cycle); pc<=redirect_pc; no fetch that cycle.
  - If redirect_pc >= len_q: state<=HALT.
  - Redirect has priority over fetch_en and over last-fetch halt.
- HALT: no fetches. A pending out_valid stays until transferred, so the final instruction is not lost. halted=1.
- Arithmetic and width rules:
  - Comparisons are unsigned, PC_W wide.
  - The pc register never wraps in practice because the halt check precedes any overflow.
  - pc advances only by loading fe_pc_4; the controller does no increment itself.
- Simultaneous events:
  - start and redirect_valid together in IDLE/HALT: start wins, redirect ignored.
  - rst with anything: reset wins.

Decomposition:
- Package fetch_pkg holds: state typedef/localparams (ST_IDLE=0, ST_RUN=1, ST_HALT=2), PC_W/INST_W defaults, RESET_PC.
- Sub-module: one pipeline register, fe_out_reg (valid/ready, data = {out_pc,out_inst}, load/flush inputs).
- `fetch` is instantiated alongside the controller by the integrating top, not inside it.

Test Plan:
- Basic run: rst, then start with prog_len=5, out_ready=1 -> out_pc sequence 0,1,2,3,4 on consecutive cycles; out_inst[0]=32'h00220020; halted=1 after the 5th fetch; out_valid=0 after the last transfer.
- Stall: hold out_ready=0 for 3 cycles while out_pc=2 -> out_pc/out_inst stay stable at 2, fe_pc stays 3; release -> out_pc 3 next cycle, no skip or duplicate.
- Redirect: in RUN with out_pc=1 valid, assert redirect_valid with redirect_pc=4 -> out_valid=0 next cycle, then out_pc=4, then HALT. With redirect_pc=7 and prog_len=5 -> HALT, no valid output.
- Halt with stalled last instruction: prog_len=2, out_ready=0 -> halted=1 with out_valid=1 and out_pc=1 held until out_ready=1, then out_valid=0.
- Restart and reset: start in HALT -> out_pc restarts at 0. rst asserted mid-run at out_pc=2 -> all outputs 0 and state IDLE next cycle. prog_len=0 -> immediate HALT, no out_valid.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default widths for the fetch sequencer.
package fetch_pkg;
  localparam int DEF_PC_W = 32;
  localparam int DEF_INST_W = 32;
  localparam int unsigned DEF_RESET_PC = 0;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;
endpackage

// File: rtl/fetch_ctrl_out_reg.sv
// fe_out_reg: one-entry valid/ready register; flush beats load, load beats drain.
module fe_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: drives the combinational fetch unit's pc and registers its output toward decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int INST_W = DEF_INST_W,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PC_W-1:0]   prog_len,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   fe_pc,
  input  logic [INST_W-1:0] fe_inst,
  input  logic [PC_W-1:0]   fe_pc_4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              busy,
  output logic              halted
);
  state_t st, st_d;
  logic [PC_W-1:0] pc, pc_d, len_q, len_d;
  logic run, fetch_en, squash;
  assign run = st == ST_RUN;
  assign squash = run && redirect_valid;
  assign fetch_en = run && (!out_valid || out_ready) && !redirect_valid;
  assign fe_pc = pc;
  assign busy = run;
  assign halted = st == ST_HALT;
  // Redirect wins over both the sequential fetch and the last-fetch halt.
  always_comb begin
    st_d = st;
    pc_d = pc;
    len_d = len_q;
    if (!run && start) begin
      pc_d = PC_W'(RESET_PC);
      len_d = prog_len;
      st_d = prog_len == '0 ? ST_HALT : ST_RUN;
    end else if (squash) begin
      pc_d = redirect_pc;
      st_d = redirect_pc >= len_q ? ST_HALT : ST_RUN;
    end else if (fetch_en) begin
      pc_d = fe_pc_4;
      st_d = pc == len_q - 1'b1 ? ST_HALT : ST_RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_IDLE;
      pc <= PC_W'(RESET_PC);
      len_q <= '0;
    end else begin
      st <= st_d;
      pc <= pc_d;
      len_q <= len_d;
    end
  end
  fe_out_reg #(.W(PC_W + INST_W)) u_out (
    .clk  (clk),
    .rst  (rst),
    .load (fetch_en),
    .flush(squash),
    .din  ({pc, fe_inst}),
    .ready(out_ready),
    .valid(out_valid),
    .dout ({out_pc, out_inst})
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors against a small instruction ROM model standing in for fetch.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst, start, redirect_valid, out_ready, out_valid, busy, halted;
  logic [31:0] prog_len, redirect_pc, fe_pc, fe_pc_4, out_pc, fe_inst, out_inst;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h00220020 + a * 32'h101;
  endfunction
  assign fe_inst = rom(fe_pc);
  assign fe_pc_4 = fe_pc + 32'd1;
  fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fe_pc(fe_pc), .fe_inst(fe_inst), .fe_pc_4(fe_pc_4),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .busy(busy), .halted(halted)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [31:0] len);
    prog_len = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; prog_len = '0; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fe_pc", fe_pc, 0);
    chk("rst_out_pc", out_pc, 0);
    go(5);
    chk("run_busy", busy, 1);
    chk("run_lat_valid", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("seq_valid", out_valid, 1);
      chk("seq_pc", out_pc, i);
      chk("seq_inst", out_inst, rom(i));
      if (i == 0) chk("first_inst", out_inst, 64'h00220020);
    end
    chk("seq_halted", halted, 1);
    step();
    chk("seq_drain", out_valid, 0);
    go(5);
    step(); chk("st_pc0", out_pc, 0);
    step(); chk("st_pc1", out_pc, 1);
    step(); chk("st_pc2", out_pc, 2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", out_pc, 2);
      chk("stall_inst", out_inst, rom(2));
      chk("stall_valid", out_valid, 1);
      chk("stall_fe_pc", fe_pc, 3);
    end
    out_ready = 1'b1;
    step(); chk("rel_pc3", out_pc, 3);
    step(); chk("rel_pc4", out_pc, 4);
    chk("rel_halted", halted, 1);
    step(); chk("rel_drain", out_valid, 0);
    go(5);
    step(); step();
    chk("rd_pre_pc", out_pc, 1);
    redirect_valid = 1'b1; redirect_pc = 32'd4;
    step();
    redirect_valid = 1'b0;
    chk("rd_squash", out_valid, 0);
    chk("rd_fe_pc", fe_pc, 4);
    chk("rd_busy", busy, 1);
    step();
    chk("rd_valid", out_valid, 1);
    chk("rd_pc", out_pc, 4);
    chk("rd_halted", halted, 1);
    step(); chk("rd_drain", out_valid, 0);
    go(5);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'd7;
    step();
    redirect_valid = 1'b0;
    chk("oor_valid", out_valid, 0);
    chk("oor_halted", halted, 1);
    step(); chk("oor_idle", out_valid, 0);
    go(2);
    step(); chk("hs_pc0", out_pc, 0);
    step();
    out_ready = 1'b0;
    chk("hs_halted", halted, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hs_valid", out_valid, 1);
      chk("hs_pc", out_pc, 1);
    end
    out_ready = 1'b1;
    step(); chk("hs_drain", out_valid, 0);
    go(5);
    step(); step(); step();
    chk("mr_pc", out_pc, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_valid", out_valid, 0);
    chk("mr_out_pc", out_pc, 0);
    chk("mr_inst", out_inst, 0);
    chk("mr_busy", busy, 0);
    chk("mr_halted", halted, 0);
    chk("mr_fe_pc", fe_pc, 0);
    redirect_valid = 1'b1; redirect_pc = 32'd3;
    step();
    redirect_valid = 1'b0;
    chk("idle_rd_pc", fe_pc, 0);
    chk("idle_rd_busy", busy, 0);
    go(0);
    chk("z_halted", halted, 1);
    chk("z_busy", busy, 0);
    chk("z_valid", out_valid, 0);
    step(); chk("z_valid2", out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
